// File: rtl/tb_stream_sequencer.sv
// Run sequencer: admits cfg_len source samples into a non-stallable DUT, tracks its
// latency with a valid delay line and frames the results onto two capture streams.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module tb_stream_sequencer #(
    parameter int MAX_LAT = 64,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [5:0]       cfg_lat,
    input  logic [31:0]      src_tdata,
    input  logic             src_tvalid,
    output logic             src_tready,
    output logic [15:0]      dut_data_in,
    input  logic [15:0]      dut_data_out,
    input  logic [63:0]      dut_testvec,
    output logic [31:0]      sink_tdata,
    output logic [3:0]       sink_tkeep,
    output logic             sink_tvalid,
    output logic             sink_tlast,
    input  logic             sink_tready,
    output logic [63:0]      tv_tdata,
    output logic [7:0]       tv_tkeep,
    output logic             tv_tvalid,
    output logic             tv_tlast,
    input  logic             tv_tready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      drop_cnt
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int LAT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   len_q, in_cnt, out_cnt;
    logic [LAT_W-1:0]   lat_q;
    logic [MAX_LAT-1:0] vpipe;
    logic               beat_vld, beat_last;
    logic               active, accept, acc, tap, issue, last_beat;
    logic               start_ok, start_zero, abort_eff, wd_fire;
    logic [WD_W-1:0]    wd_cnt;
    logic               unused_ok;

    assign active      = (state == RUN) || (state == DRAIN);
    assign busy        = active;
    assign src_tready  = (state == RUN) && (in_cnt < len_q);
    assign accept      = src_tvalid && src_tready;
    assign start_ok    = (state == IDLE) && cfg_start && (cfg_len != '0);
    assign start_zero  = (state == IDLE) && cfg_start && (cfg_len == '0);
    assign abort_eff   = active && (cfg_abort || wd_fire);
    // An accept coinciding with an abort is discarded along with the run.
    assign acc         = accept && !abort_eff;
    assign tap         = vpipe[lat_q];
    assign issue       = active && tap && !abort_eff;
    assign last_beat   = (state == DRAIN) && beat_vld && beat_last;

    assign sink_tkeep  = 4'hF;
    assign tv_tkeep    = 8'hFF;
    assign sink_tvalid = beat_vld;
    assign tv_tvalid   = beat_vld;
    assign sink_tlast  = beat_last;
    assign tv_tlast    = beat_last;
    assign unused_ok   = ^{src_tdata[31:16], wd_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_ok) state_n = RUN;
            RUN: begin
                if (abort_eff)                           state_n = IDLE;
                else if (acc && (in_cnt == len_q - 1'b1)) state_n = DRAIN;
            end
            DRAIN: begin
                if (abort_eff)      state_n = IDLE;
                else if (last_beat) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            lat_q       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            vpipe       <= '0;
            dut_data_in <= '0;
            sink_tdata  <= '0;
            tv_tdata    <= '0;
            beat_vld    <= 1'b0;
            beat_last   <= 1'b0;
            drop_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            done <= start_zero || (last_beat && !abort_eff);

            if (start_ok) begin
                len_q   <= cfg_len;
                lat_q   <= (32'(cfg_lat) >= MAX_LAT) ? LAT_W'(MAX_LAT - 1) : LAT_W'(cfg_lat);
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (acc) begin
                in_cnt <= in_cnt + 1'b1;
            end

            if (acc) dut_data_in <= src_tdata[15:0];

            // Stale bits past the tap would fire on a later run with a longer latency.
            if (!active || abort_eff) vpipe <= '0;
            else                      vpipe <= {vpipe[MAX_LAT-2:0], acc};

            beat_vld  <= issue;
            beat_last <= issue && (out_cnt == len_q - 1'b1);
            if (issue) begin
                sink_tdata <= {16'h0, dut_data_out};
                tv_tdata   <= dut_testvec;
                out_cnt    <= out_cnt + 1'b1;
            end

            if (start_ok)
                drop_cnt <= '0;
            else if (beat_vld && !(sink_tready && tv_tready) && !abort_eff && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Uses the raw handshake so the abort path does not loop back through acc.
    assign wd_fire = active && !accept && !beat_vld && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (!active || accept || beat_vld || wd_fire) wd_cnt <= '0;
            else                                          wd_cnt <= wd_cnt + 1'b1;

            if (wd_fire)                           timeout <= 1'b1;
            else if ((state == IDLE) && cfg_start) timeout <= 1'b0;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign wd_cnt  = '0;
`endif

endmodule

// File: doc/tb_stream_sequencer.md
Name: tb_stream_sequencer

Overview:
- Run controller between the DMA MM2S source stream, the non-stallable FIR DUT, and the two S2MM capture streams (sink and testvec).
- On a start command it admits exactly cfg_len samples from the source into the DUT.
- It tracks DUT pipeline latency with a valid delay line, then emits framed beats with tvalid/tlast on both capture streams.
- It counts beats dropped because a capture stream was not ready, and reports busy, done and status.

Parameters:
- MAX_LAT, 64, depth of the valid delay line; cfg_lat must be < MAX_LAT.
- LEN_W, 32, width of the sample-count configuration and counters.
- TIMEOUT, 1048576, watchdog cycle limit (only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  tb_clk domain; all logic is on this clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle start pulse.
- cfg_abort  in  1  one-cycle abort pulse.
- cfg_len  in  LEN_W  samples per run; latched at start.
- cfg_lat  in  6  DUT latency in cycles; latched at start.
- src_tdata  in  32  MM2S data.
- src_tvalid  in  1  MM2S valid.
- src_tready  out  1  MM2S ready.
- dut_data_in  out  16  src_tdata[15:0], registered on acceptance.
- dut_data_out  in  16  FIR output.
- dut_testvec  in  64  DUT probe vector.
- sink_tdata  out  32  {16'h0, captured dut_data_out}.
- sink_tkeep  out  4  constant 4'hF.
- sink_tvalid  out  1  sink beat valid.
- sink_tlast  out  1  last beat of the run.
- sink_tready  in  1  sink ready.
- tv_tdata  out  64  captured dut_testvec.
- tv_tkeep  out  8  constant 8'hFF.
- tv_tvalid  out  1  testvec beat valid.
- tv_tlast  out  1  last beat of the run.
- tv_tready  in  1  testvec ready.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at end of run.
- drop_cnt  out  16  saturating count of dropped beats.
- timeout  out  1  sticky watchdog flag (only with SEQ_TIMEOUT_EN).

Behaviour:
- Reset: every output 0 except tkeep constants; state IDLE; counters, delay line and dut_data_in cleared.
- IDLE:
  - cfg_start with cfg_len != 0: latch len/lat, clear in_cnt, out_cnt and drop_cnt, go to RUN.
  - cfg_start with cfg_len == 0: done pulses next cycle, no beats issued, stay IDLE.
- RUN:
  - src_tready = (in_cnt < len).
  - Accept = src_tvalid & src_tready. It loads dut_data_in, increments in_cnt and shifts 1 into vpipe[0]; otherwise 0 is shifted in.
  - Go to DRAIN on the cycle in_cnt reaches len.
- vpipe is a shift register of MAX_LAT bits, shifting every cycle in RUN and DRAIN.
  - Tap = vpipe[lat]. When the tap is high, register dut_data_out into sink_tdata and dut_testvec into tv_tdata, and assert sink_tvalid and tv_tvalid for exactly one cycle.
  - Timing: accept at cycle t gives the beat valid at t+lat+2.
- No backpressure to the DUT:
  - A beat is held for one cycle only.
  - If sink_tready or tv_tready is low during that cycle, drop_cnt increments by 1 (by 1 even if both are low). It saturates at 16'hFFFF.
- out_cnt increments per issued beat, whether accepted or dropped. sink_tlast and tv_tlast are high on the beat where out_cnt == len-1.
- DRAIN: src_tready = 0. After the final beat cycle, go to IDLE and pulse done in the following cycle.
- cfg_abort in RUN or DRAIN:
  - Next cycle: IDLE, vpipe cleared, tvalids and src_tready low, no done pulse.
  - drop_cnt is held.
- cfg_start while busy is ignored. Start and abort in the same cycle in IDLE: start wins. Both while busy: abort wins.
- rst mid-run returns to reset values immediately; no partial tlast is emitted.
- Arithmetic:
  - in_cnt and out_cnt are LEN_W unsigned.
  - len == 2^LEN_W-1 must work.
  - A cfg_lat value >= MAX_LAT is clamped to MAX_LAT-1.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in RUN/DRAIN without an accept or an issued beat.
  - At TIMEOUT it behaves as cfg_abort and sets timeout. timeout stays set until the next accepted cfg_start or rst.
- Undefined: no watchdog and no timeout port; a stalled source holds RUN indefinitely.

Test Plan:
- len=8, lat=3, source always valid, sinks ready:
  - 8 sink beats, the first at 5 cycles after the first accept.
  - tlast only on the 8th beat; done pulses once; drop_cnt=0.
- len=4, src_tvalid toggling 1010...: exactly 4 accepts; beats keep the same gaps shifted by lat+2; tlast on the 4th.
- len=16, sink_tready low for beats 5-6, tv_tready low for beat 6: drop_cnt=2; 16 beats issued; done asserted.
- len=100, abort at in_cnt=40: next cycle busy=0, no tvalid, no done. A following start with len=2 completes normally.
- len=0 start: done pulse 1 cycle later, no tvalid, src_tready stays 0. A start during RUN is ignored, with no counter reset.
- SEQ_TIMEOUT_EN, TIMEOUT=16: src_tvalid stuck low after 3 accepts. After 16 idle cycles: timeout=1, busy=0, no done.
